// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU definitions: controller state encoding and
//                legal width bounds for the serial arithmetic path.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

  // Controller state encoding (2-bit, shared by ALU sequencers)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MIN_WIDTH = 1;
  localparam int MAX_WIDTH = 32;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/serial_add_ctrl_fulladder.sv
`default_nettype none
// ============================================================================
//  Module      : fulladder
//  Description : One-bit full adder; the only arithmetic element of the
//                bit-serial adder/subtractor.
//  Revision    : 1.0  initial release
// ============================================================================
module fulladder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule : fulladder
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Bit-serial adder/subtractor controller. Operands are latched
//                on Start, processed LSB first through a single shared full
//                adder, one bit per clock, and the result is published with
//                a one-cycle Done pulse. Subtraction is A + ~B + ~Cin.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);

  import alu_pkg::*;

  localparam int             CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  c_last_bit = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_b_next;
  logic [WIDTH-1:0] w_res_next;

  // Shared full adder always works on the current LSB of the operand shifters
  fulladder u_fa (
    .A    (r_a[0]),
    .B    (r_b[0]),
    .Cin  (r_carry),
    .Sum  (w_fa_sum),
    .Cout (w_fa_cout)
  );

  // Operands shift right toward the adder; result bits enter at the MSB so the
  // first computed bit lands in bit 0 after WIDTH shifts
  if (WIDTH == 1) begin : g_w1
    assign w_a_next   = 1'b0;
    assign w_b_next   = 1'b0;
    assign w_res_next = w_fa_sum;
  end else begin : g_wn
    assign w_a_next   = {1'b0, r_a[WIDTH-1:1]};
    assign w_b_next   = {1'b0, r_b[WIDTH-1:1]};
    assign w_res_next = {w_fa_sum, r_res[WIDTH-1:1]};
  end

  // Sequencer: accept, one bit per cycle, publish, single-cycle DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      Sum      <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            r_a     <= A;
            r_b     <= Sub ? ~B : B;
            r_carry <= Sub ? ~Cin : Cin;
            r_res   <= '0;
            r_cnt   <= '0;
            Busy    <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a     <= w_a_next;
          r_b     <= w_b_next;
          r_res   <= w_res_next;
          r_carry <= w_fa_cout;
          if (r_cnt == c_last_bit) begin
            // r_carry is still the carry into the MSB at this edge
            Sum      <= w_res_next;
            Cout     <= w_fa_cout;
            Overflow <= r_carry ^ w_fa_cout;
            Busy     <= 1'b0;
            Done     <= 1'b1;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          Done    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          Busy    <= 1'b0;
          Done    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : serial_add_ctrl
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_ctrl
//  Description : Self-checking bench for serial_add_ctrl, WIDTH=8 and WIDTH=1
//                instances, against an integer arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [7:0] sum8;
  logic       cout8, ov8, busy8, done8;

  logic       start1 = 1'b0, cin1 = 1'b0, sub1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [0:0] sum1;
  logic       cout1, ov1, busy1, done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .Start(start8), .A(a8), .B(b8), .Cin(cin8), .Sub(sub8),
    .Sum(sum8), .Cout(cout8), .Overflow(ov8), .Busy(busy8), .Done(done8)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .Start(start1), .A(a1), .B(b1), .Cin(cin1), .Sub(sub1),
    .Sum(sum1), .Cout(cout1), .Overflow(ov1), .Busy(busy1), .Done(done1)
  );

  // Integer model: true sums/differences, carry = unsigned result fits, overflow = signed result out of range
  function automatic void model(input int w, input longint a, input longint b,
                                input int cin, input int sub,
                                output longint sum, output int cout, output int ov);
    longint m, half, r, sa, sb, sr;
    m    = 64'sd1 << w;
    half = m / 2;
    if (sub == 0) begin
      r    = a + b + cin;
      cout = (r >= m) ? 1 : 0;
    end else begin
      r    = a - b - cin;
      cout = (r >= 0) ? 1 : 0;
    end
    sum = ((r % m) + m) % m;
    sa  = (a >= half) ? a - m : a;
    sb  = (b >= half) ? b - m : b;
    sr  = (sub == 0) ? sa + sb + cin : sa - sb - cin;
    ov  = (sr < -half || sr > half - 1) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation with full cycle-by-cycle timing checks
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    longint es;
    int     ec, eo;
    model(8, longint'(a), longint'(b), int'(cin), int'(sub), es, ec, eo);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = cin; sub8 = sub;
    @(posedge clk); #1;
    chk("busy_accept", 32'(busy8), 32'd1);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k < 8) begin
        chk("done_early", 32'(done8), 32'd0);
        chk("busy_run", 32'(busy8), 32'd1);
      end
    end
    chk("done8", 32'(done8), 32'd1);
    chk("busy_done", 32'(busy8), 32'd0);
    chk("sum8", 32'(sum8), 32'(es[7:0]));
    chk("cout8", 32'(cout8), 32'(ec));
    chk("ov8", 32'(ov8), 32'(eo));
    @(posedge clk); #1;
    chk("done_pulse", 32'(done8), 32'd0);
    chk("sum8_hold", 32'(sum8), 32'(es[7:0]));
  endtask

  // One WIDTH=1 operation: Done one cycle after accept
  task automatic op1(input logic a, input logic b, input logic cin, input logic sub);
    longint es;
    int     ec, eo;
    model(1, longint'(a), longint'(b), int'(cin), int'(sub), es, ec, eo);
    @(negedge clk);
    start1 = 1'b1; a1 = a; b1 = b; cin1 = cin; sub1 = sub;
    @(posedge clk); #1;
    chk("w1_busy", 32'(busy1), 32'd1);
    chk("w1_done_early", 32'(done1), 32'd0);
    start1 = 1'b0;
    @(posedge clk); #1;
    chk("w1_done", 32'(done1), 32'd1);
    chk("w1_sum", 32'(sum1), 32'(es[0]));
    chk("w1_cout", 32'(cout1), 32'(ec));
    chk("w1_ov", 32'(ov1), 32'(eo));
    @(posedge clk); #1;
    chk("w1_done_pulse", 32'(done1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ha [0:18];
    logic [7:0] hb [0:18];
    logic       hc [0:18];
    logic       hs [0:18];
    longint     es;
    int         ec, eo, idx;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum8", 32'(sum8), 32'd0);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_cout8", 32'(cout8), 32'd0);
    chk("rst_ov8", 32'(ov8), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed arithmetic cases
    op8(8'h5A, 8'h3C, 1'b0, 1'b0);
    chk("dir_5a3c", 32'(sum8), 32'h96);
    chk("dir_5a3c_ov", 32'(ov8), 32'd1);
    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    chk("dir_wrap", 32'(sum8), 32'h00);
    chk("dir_wrap_c", 32'(cout8), 32'd1);
    op8(8'h00, 8'h00, 1'b1, 1'b0);
    chk("dir_cin", 32'(sum8), 32'h01);
    op8(8'h10, 8'h20, 1'b0, 1'b1);
    chk("dir_sub", 32'(sum8), 32'hF0);
    chk("dir_sub_c", 32'(cout8), 32'd0);
    op8(8'h80, 8'h01, 1'b0, 1'b1);
    chk("dir_sub_ov", 32'(ov8), 32'd1);
    chk("dir_sub_c2", 32'(cout8), 32'd1);

    // Randomized operations
    for (int i = 0; i < 24; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    // Start held high through RUN and DONE with operands changing every cycle
    @(negedge clk);
    start8 = 1'b1;
    for (int c = 0; c <= 18; c++) begin
      ha[c] = 8'($urandom); hb[c] = 8'($urandom);
      hc[c] = 1'($urandom); hs[c] = 1'($urandom);
      a8 = ha[c]; b8 = hb[c]; cin8 = hc[c]; sub8 = hs[c];
      @(posedge clk); #1;
      if (c == 0 || c == 10) chk("hold_accept", 32'(busy8), 32'd1);
      if (c == 9) chk("hold_idle_gap", 32'(busy8), 32'd0);
      if (c == 8 || c == 18) begin
        idx = c - 8;
        model(8, longint'(ha[idx]), longint'(hb[idx]), int'(hc[idx]), int'(hs[idx]), es, ec, eo);
        chk("hold_done", 32'(done8), 32'd1);
        chk("hold_sum", 32'(sum8), 32'(es[7:0]));
        chk("hold_cout", 32'(cout8), 32'(ec));
        chk("hold_ov", 32'(ov8), 32'(eo));
      end else begin
        chk("hold_no_done", 32'(done8), 32'd0);
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    @(posedge clk); #1;
    chk("hold_pulse_end", 32'(done8), 32'd0);

    // Asynchronous reset after three bits of a run
    op8(8'h5A, 8'h3C, 1'b0, 1'b0);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; sub8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy8), 32'd0);
    chk("arst_sum", 32'(sum8), 32'd0);
    chk("arst_cout", 32'(cout8), 32'd0);
    chk("arst_ov", 32'(ov8), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 2) rst = 1'b0;
      chk("arst_no_done", 32'(done8), 32'd0);
    end
    op8(8'h5A, 8'h3C, 1'b0, 1'b0);

    // WIDTH=1: every operand combination in both modes
    for (int v = 0; v < 16; v++)
      op1(1'(v), 1'(v >> 1), 1'(v >> 2), 1'(v >> 3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_add_ctrl
`default_nettype wire

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder/subtractor controller that shares a single `fulladder` instance across a WIDTH-bit word, one bit per clock.
- Accepts operands on a start handshake and sequences LSB to MSB, carrying the result through a carry flop.
- Presents Sum/Cout/Overflow with a one-cycle Done pulse.
- Sits in the ALU as the low-area arithmetic path beside the combinational adder.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- Start  input  1  request to begin an operation; sampled only in IDLE
- A  input  WIDTH  operand A; latched when Start is accepted
- B  input  WIDTH  operand B; latched when Start is accepted
- Cin  input  1  carry-in (add) or borrow-in (sub); latched on accept
- Sub  input  1  0 = A+B+Cin, 1 = A-B-Cin; latched on accept
- Sum  output  WIDTH  result; updated only on completion
- Cout  output  1  final carry out of the MSB (sub mode: 1 = no borrow)
- Overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB
- Busy  output  1  high while in RUN
- Done  output  1  one-cycle pulse when Sum/Cout/Overflow become valid

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - Sum, Cout, Overflow, Busy, Done = 0.
  - Bit counter, operand shift registers and carry flop cleared.
  - Reset during RUN aborts the operation: no Done pulse, outputs read 0.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - Start=1 at edge E0 → latch A, B' = Sub ? ~B : B, carry = Sub ? ~Cin : Cin; counter = 0; go to RUN.
  - Busy=1 from E0.
  - Start=0 → remain in IDLE; outputs hold.
- RUN, edge E(k+1) for k = 0..WIDTH-1:
  - fulladder inputs: A[k], B'[k], carry.
  - Sum bit shifted into the internal result register; carry flop takes Cout.
  - At bit k = WIDTH-1, capture the carry-in of that bit for Overflow.
  - Start is ignored throughout RUN (no queueing, no restart).
  - After edge E(WIDTH): load Sum, Cout and Overflow from the internal registers; go to DONE; Busy=0, Done=1.
- DONE:
  - Lasts exactly one cycle; returns to IDLE at the next edge; Done returns to 0.
  - Start in DONE is ignored.
  - Earliest new accept is the edge after returning to IDLE.
- Latency and throughput:
  - Done is high in the cycle following edge E(WIDTH), i.e. WIDTH cycles after the accept edge.
  - Throughput: one operation per WIDTH+2 cycles.
- Holding and arithmetic:
  - Sum/Cout/Overflow hold their values until the next completion or reset.
  - All arithmetic is modulo 2^WIDTH.
- WIDTH=1: single RUN cycle. Overflow = Cin_eff XOR Cout, with the carry into the MSB equal to the initial carry.
- Counter width: $clog2(WIDTH+1). Terminal count compares against WIDTH-1.

Decomposition:
- Shared package `alu_pkg`: state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
- One sub-module: the existing `fulladder` (ports A, B, Cin, Sum, Cout), instantiated exactly once. No other arithmetic in the block.

Test Plan:
- WIDTH=8, add: A=8'h5A, B=8'h3C, Cin=0, Start pulse → Done exactly 8 cycles after accept; Sum=8'h96, Cout=0, Overflow=1; Busy high for 8 cycles.
- Add with wrap: A=8'hFF, B=8'h01, Cin=0 → Sum=8'h00, Cout=1, Overflow=0. Then A=8'h00, B=8'h00, Cin=1 → Sum=8'h01, Cout=0.
- Subtract: Sub=1, A=8'h10, B=8'h20, Cin=0 → Sum=8'hF0, Cout=0, Overflow=0. Sub=1, A=8'h80, B=8'h01 → Sum=8'h7F, Cout=1, Overflow=1.
- Start held high continuously through RUN and DONE with changing A/B → only the first operands are used.
  - Result matches the first operands only.
  - Next accept occurs one cycle after DONE.
  - Done pulses are exactly 1 cycle wide.
- Reset asserted asynchronously mid-RUN (after 3 bits) of 8'h5A+8'h3C → immediately Busy=0, Sum=0. No Done pulse. Next Start after reset release completes correctly.
- WIDTH=1 build, all 8 combinations of A, B, Cin with Sub=0 → Sum/Cout match the full-adder truth table. Done occurs 1 cycle after accept.
